spi2_slave: RTL and testbench
=============================

# spi2_slave

SPI mode-0 slave (responder) for the same serial link driven by the on-chip SPI2 master: frame length is selectable from 1 to 32 bits, MSB first, full duplex. The block oversamples `sck`, `ss_n` and `mosi` in the `clk` domain, so the whole design stays synchronous. It exposes a single-entry transmit buffer and a single-entry receive buffer, with ready, empty and overrun flags, to the host bus. Typical use is SoC-to-SoC links and loopback verification of the master.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on `sck`, `ss_n` and `mosi`.
- `clk` in 1: system clock. Single clock domain.
- `resetb` in 1: reset, asynchronous, active-low.
- `sck` in 1: SPI clock from the master. Asynchronous.
- `ss_n` in 1: slave select, active-low. Asynchronous.
- `mosi` in 1: serial data in. Asynchronous.
- `miso` out 1: serial data out.
- `miso_oe` out 1: output enable for the `miso` pad. High while the synchronized `ss_n` is low.
- `wr` in 1: one-cycle pulse that writes `din` into the TX buffer.
- `din` in 32: TX data. Only bits [bits-1:0] are used.
- `bits` in 6: frame length. Sampled at frame start.
- `rd` in 1: one-cycle pulse that acknowledges RX. Clears `rxrdy` and `ovr`.
- `dout` out 32: last received frame, right-aligned, upper bits zero.
- `rxrdy` out 1: new frame present in `dout`.
- `txempty` out 1: TX buffer is free.
- `ovr` out 1: a frame completed while `rxrdy` was still set.
- `busy` out 1: frame in progress.

## Operation
- Reset values: `miso`=0, `miso_oe`=0, `dout`=0, `rxrdy`=0, `ovr`=0, `busy`=0, `txempty`=1. Shift register, bit counter and latched length are all cleared.
- Input conditioning: each of the three SPI inputs passes through SYNC_STAGES flops plus one history flop. Edge pulses are one `clk` wide.
- States: IDLE, SHIFT, DONE.
- IDLE → SHIFT on the synchronized `ss_n` falling edge:
  - `bits` is latched as `nb`. A value of 0 aborts to DONE with no transfer. Values above 32 are clamped to 32.
  - The shift register loads the TX buffer if `txempty`=0, otherwise it loads 0 (underrun, no flag).
  - `txempty` is set to 1 and the counter loads `nb`.
- SHIFT:
  - On an `sck` rising edge: sample `mosi` into `sin`.
  - On an `sck` falling edge: shift left by one, inserting `sin` at bit 0. Bits at or above `nb` are forced to 0. Decrement the counter.
- When the counter goes 1→0, move to DONE:
  - `dout` takes the shifted value and `rxrdy` is set.
  - If `rxrdy` was already 1 and `rd` is not asserted in the same cycle, `ovr` is set and `dout` is overwritten.
- DONE → IDLE on the `ss_n` rising edge. While in DONE, `sck` edges are ignored and `miso` holds 0.
- Abort: an `ss_n` rising edge during SHIFT returns to IDLE. `dout`, `rxrdy` and `ovr` are unchanged and the partial frame is discarded.
- `sck` edges while `ss_n` is high are ignored.
- `miso` = shift[nb-1] in SHIFT, 0 otherwise.
- `wr` during SHIFT updates only the TX buffer; it takes effect on the next frame. `wr` on the same cycle as frame start: the old buffer content is used and the new content stays pending (`txempty`=0).
- `rd` on the same cycle as completion: `rxrdy` stays 1 and `ovr` is not set.
- A `bits` change mid-frame has no effect on the current frame.

## Timing
- Pin to internal edge pulse: SYNC_STAGES+1 `clk` cycles.
- `miso` first bit is valid SYNC_STAGES+2 cycles after the `ss_n` pin falls. The master must leave at least 5 `clk` cycles from `ss_n` low to the first `sck` rise.
- `miso` update follows the `sck` falling pin edge by SYNC_STAGES+2 cycles. Each `sck` phase must be ≥5 `clk` cycles, which corresponds to master divider ≥4 on a shared clock.
- `rxrdy` and `dout` update SYNC_STAGES+2 cycles after the last `sck` falling pin edge.
- `txempty` rises one cycle after the frame-start edge pulse.

## Structure
- Package `spi2_pkg`:
  - `SPI2_MAXBITS`=32
  - `SPI2_BITSW`=6
  - state enum `spi2_slv_state_t` {IDLE, SHIFT, DONE}
- Sub-module `spi2_sync`: SYNC_STAGES synchronizer plus rise/fall pulse outputs. Instantiated three times, once each for `sck`, `ss_n` and `mosi`.

## Test plan
- `bits`=8, `din`=0xA5 preloaded, master sends 0x3C → `dout`=0x0000003C, `rxrdy`=1, master receives 0xA5, `txempty`=1.
- `bits`=32, `din`=0xDEADBEEF, master sends 0x12345678 → `dout`=0x12345678, master receives 0xDEADBEEF. Then `bits`=1 with `din` bit0=1 and master sending 1 → `dout`=0x00000001.
- Two 8-bit frames with no `rd` in between → `ovr`=1 and `dout` = second frame. `rd` → `rxrdy`=0, `ovr`=0.
- `ss_n` raised after 5 of 12 bits → `busy`=0, `rxrdy` and `dout` unchanged. The next full frame completes normally.
- No `wr` before a frame → master receives 0x00. Toggling `sck` with `ss_n` high → no state change.
- `resetb` asserted mid-frame → all outputs return to their reset values immediately. A frame after release works normally.

Source files
------------

// File: rtl/spi2_pkg.sv
// Shared constants, state encoding and frame-mask helper for the SPI2 slave.
package spi2_pkg;

  localparam int SPI2_MAXBITS = 32;
  localparam int SPI2_BITSW   = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi2_slv_state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Ones in bits [nb-1:0]; nb is already clamped to 0..32.
  function automatic logic [SPI2_MAXBITS-1:0] spi2_mask(input logic [SPI2_BITSW-1:0] nb);
    logic [SPI2_MAXBITS-1:0] m;
    m = '0;
    for (int i = 0; i < SPI2_MAXBITS; i++) begin
      if (i < int'(nb)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/spi2_sync.sv
// Multi-stage synchronizer with one history flop and registered one-cycle edge pulses.
module spi2_sync #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic resetb,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;

  // level is the history flop, so it lines up with the rise/fall pulses.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sync_q <= {STAGES{INIT}};
      level  <= INIT;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= STAGES'({sync_q, pin});
      level  <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~level;
      fall   <= ~sync_q[STAGES-1] & level;
    end
  end

endmodule

// File: rtl/spi2_slave.sv
// SPI mode-0 slave, oversampled in the clk domain, with single-entry TX and RX buffers.
module spi2_slave
  import spi2_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    resetb,
  input  logic                    sck,
  input  logic                    ss_n,
  input  logic                    mosi,
  output logic                    miso,
  output logic                    miso_oe,
  input  logic                    wr,
  input  logic [SPI2_MAXBITS-1:0] din,
  input  logic [SPI2_BITSW-1:0]   bits,
  input  logic                    rd,
  output logic [SPI2_MAXBITS-1:0] dout,
  output logic                    rxrdy,
  output logic                    txempty,
  output logic                    ovr,
  output logic                    busy
);

  logic                    sck_rise, sck_fall, ss_rise, ss_fall, ss_level, mosi_level;
  logic [2:0]              edges_unused;
  logic [1:0]              state;
  logic [SPI2_BITSW-1:0]   nb, cnt, start_nb;
  logic [SPI2_MAXBITS-1:0] shreg, shift_next, txbuf;
  logic                    sin;
  logic [4:0]              miso_idx;

  spi2_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sck_sync (
    .clk(clk), .resetb(resetb), .pin(sck),
    .level(edges_unused[0]), .rise(sck_rise), .fall(sck_fall)
  );

  spi2_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_ss_sync (
    .clk(clk), .resetb(resetb), .pin(ss_n),
    .level(ss_level), .rise(ss_rise), .fall(ss_fall)
  );

  spi2_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_mosi_sync (
    .clk(clk), .resetb(resetb), .pin(mosi),
    .level(mosi_level), .rise(edges_unused[1]), .fall(edges_unused[2])
  );

  assign start_nb   = (bits > 6'd32) ? 6'd32 : bits;
  assign shift_next = {shreg[SPI2_MAXBITS-2:0], sin} & spi2_mask(nb);
  assign miso_idx   = 5'(nb - 6'd1);
  assign miso       = (state == ST_SHIFT) ? shreg[miso_idx] : 1'b0;
  assign miso_oe    = ~ss_level;
  assign busy       = (state == ST_SHIFT);

  // Host side: wr and rd are single-cycle strobes with no back-pressure; txempty,
  // rxrdy and ovr tell the host when a strobe is useful or data was lost.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state   <= ST_IDLE;
      nb      <= '0;
      cnt     <= '0;
      shreg   <= '0;
      sin     <= 1'b0;
      txbuf   <= '0;
      txempty <= 1'b1;
      dout    <= '0;
      rxrdy   <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      if (wr) begin
        txbuf   <= din;
        txempty <= 1'b0;
      end
      if (rd) begin
        rxrdy <= 1'b0;
        ovr   <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (ss_fall) begin
            nb <= start_nb;
            if (start_nb == 6'd0) begin
              state <= ST_DONE;
            end else begin
              state <= ST_SHIFT;
              cnt   <= start_nb;
              shreg <= txempty ? '0 : (txbuf & spi2_mask(start_nb));
              // A write on the start cycle stays pending for the next frame.
              if (!wr) txempty <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          if (ss_rise) begin
            state <= ST_IDLE;
          end else begin
            if (sck_rise) sin <= mosi_level;
            if (sck_fall) begin
              shreg <= shift_next;
              cnt   <= cnt - 6'd1;
              if (cnt == 6'd1) begin
                state <= ST_DONE;
                dout  <= shift_next;
                rxrdy <= 1'b1;
                if (rxrdy && !rd) ovr <= 1'b1;
              end
            end
          end
        end
        ST_DONE: begin
          if (ss_rise) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi2_slave.sv
// Bench for spi2_slave: bit-banged SPI master, reference model and dout scoreboard.
module tb_spi2_slave;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        sck = 1'b0;
  logic        ss_n = 1'b1;
  logic        mosi = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [31:0] din = '0;
  logic [5:0]  bits = 6'd8;
  logic        miso, miso_oe, rxrdy, txempty, ovr, busy;
  logic [31:0] dout;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];

  // reference model state
  logic        tx_pending = 1'b0;
  logic [31:0] tx_word = '0;
  logic [31:0] last_dout = '0;

  always #5 clk = ~clk;

  spi2_slave #(.SYNC_STAGES(2)) dut (
    .clk(clk), .resetb(resetb), .sck(sck), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .wr(wr), .din(din), .bits(bits),
    .rd(rd), .dout(dout), .rxrdy(rxrdy), .txempty(txempty), .ovr(ovr), .busy(busy)
  );

  function automatic logic [31:0] frame_mask(input int nb);
    logic [63:0] m;
    m = (64'd1 << nb) - 64'd1;
    return m[31:0];
  endfunction

  function automatic int clamp_bits(input int b);
    return (b > 32) ? 32 : b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_tx(input logic [31:0] d);
    @(negedge clk);
    din = d;
    wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    tx_pending = 1'b1;
    tx_word = d;
  endtask

  task automatic ack_rx();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic ss_low();
    @(negedge clk);
    ss_n = 1'b0;
    clk_wait(HALF);
  endtask

  task automatic ss_high();
    clk_wait(HALF);
    ss_n = 1'b1;
    clk_wait(HALF);
  endtask

  // Master drives mosi on the falling edge and samples miso just before the rising edge.
  task automatic xfer_bit(input logic b, output logic m);
    mosi = b;
    clk_wait(HALF);
    m = miso;
    sck = 1'b1;
    clk_wait(HALF);
    sck = 1'b0;
  endtask

  task automatic run_frame(input int b, input logic [31:0] mdata);
    int          nb;
    logic [31:0] tx_exp, rx;
    logic        m;
    nb = clamp_bits(b);
    bits = 6'(b);
    tx_exp = tx_pending ? (tx_word & frame_mask(nb)) : 32'h0;
    tx_pending = 1'b0;
    last_dout = mdata & frame_mask(nb);
    exp_q.push_back(last_dout);
    rx = '0;
    ss_low();
    for (int i = nb - 1; i >= 0; i--) begin
      xfer_bit(mdata[i], m);
      rx = {rx[30:0], m};
    end
    ss_high();
    check("master_rx", rx, tx_exp);
  endtask

  task automatic run_abort(input int b, input logic [31:0] mdata, input int nsend);
    int   nb;
    logic m;
    nb = clamp_bits(b);
    bits = 6'(b);
    tx_pending = 1'b0;
    ss_low();
    for (int i = 0; i < nsend; i++) xfer_bit(mdata[nb - 1 - i], m);
    ss_high();
  endtask

  // Monitor: a completion shows as rxrdy rising, ovr rising or dout changing.
  initial begin
    logic [31:0] p_dout;
    logic        p_rxrdy, p_ovr;
    p_dout = '0;
    p_rxrdy = 1'b0;
    p_ovr = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (resetb) begin
        if ((rxrdy && !p_rxrdy) || (ovr && !p_ovr) || (dout !== p_dout)) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame: got dout 0x%08h expected no completion at %0t", dout, $time);
          end else begin
            check("sb_dout", dout, exp_q.pop_front());
          end
        end
      end
      p_dout = dout;
      p_rxrdy = rxrdy;
      p_ovr = ovr;
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_miso"}, 32'(miso), 32'h0);
    check({tag, "_miso_oe"}, 32'(miso_oe), 32'h0);
    check({tag, "_dout"}, dout, 32'h0);
    check({tag, "_rxrdy"}, 32'(rxrdy), 32'h0);
    check({tag, "_ovr"}, 32'(ovr), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_txempty"}, 32'(txempty), 32'h1);
  endtask

  initial begin
    logic m;
    int   wait_cnt;

    // reset
    clk_wait(3);
    check_reset_values("reset");
    resetb = 1'b1;
    clk_wait(4);

    // basic 8-bit frame
    write_tx(32'h0000_00A5);
    check("txempty_after_wr", 32'(txempty), 32'h0);
    run_frame(8, 32'h0000_003C);
    check("t1_dout", dout, 32'h0000_003C);
    check("t1_rxrdy", 32'(rxrdy), 32'h1);
    check("t1_txempty", 32'(txempty), 32'h1);
    ack_rx();
    check("t1_rxrdy_ack", 32'(rxrdy), 32'h0);

    // 32-bit and 1-bit frames
    write_tx(32'hDEAD_BEEF);
    run_frame(32, 32'h1234_5678);
    check("t2_dout32", dout, 32'h1234_5678);
    ack_rx();
    write_tx(32'h0000_0001);
    run_frame(1, 32'h0000_0001);
    check("t2_dout1", dout, 32'h0000_0001);
    ack_rx();

    // overrun
    run_frame(8, 32'h0000_0011);
    run_frame(8, 32'h0000_0022);
    check("ovr_set", 32'(ovr), 32'h1);
    check("ovr_dout", dout, 32'h0000_0022);
    check("ovr_rxrdy", 32'(rxrdy), 32'h1);
    ack_rx();
    check("ovr_ack_rxrdy", 32'(rxrdy), 32'h0);
    check("ovr_ack_ovr", 32'(ovr), 32'h0);

    // abort after 5 of 12 bits, then a full frame
    run_abort(12, 32'h0000_0ABC, 5);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_rxrdy", 32'(rxrdy), 32'h0);
    check("abort_dout", dout, last_dout);
    write_tx(32'h0000_0F0F);
    run_frame(12, 32'h0000_0963);
    ack_rx();

    // underrun: no write -> master receives zero
    run_frame(8, 32'h0000_00E7);
    ack_rx();

    // sck toggling with ss_n high does nothing
    for (int i = 0; i < 4; i++) begin
      mosi = 1'($urandom_range(0, 1));
      clk_wait(HALF);
      sck = 1'b1;
      clk_wait(HALF);
      sck = 1'b0;
    end
    clk_wait(HALF);
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_rxrdy", 32'(rxrdy), 32'h0);
    check("idle_dout", dout, last_dout);
    check("idle_miso_oe", 32'(miso_oe), 32'h0);
    check("idle_txempty", 32'(txempty), 32'h1);

    // randomized frames, including lengths above 32
    for (int n = 0; n < 15; n++) begin
      int          b;
      logic [31:0] d;
      b = $urandom_range(1, 40);
      d = $urandom;
      if ($urandom_range(0, 3) != 0) write_tx($urandom);
      run_frame(b, d);
      ack_rx();
    end

    // reset mid-frame
    write_tx(32'h0000_CAFE);
    bits = 6'd16;
    ss_low();
    for (int i = 0; i < 4; i++) xfer_bit(1'b1, m);
    @(negedge clk);
    resetb = 1'b0;
    #1;
    check_reset_values("midreset");
    ss_n = 1'b1;
    sck = 1'b0;
    mosi = 1'b0;
    tx_pending = 1'b0;
    last_dout = '0;
    clk_wait(3);
    resetb = 1'b1;
    clk_wait(5);
    write_tx(32'h0000_005A);
    run_frame(8, 32'h0000_00C3);
    check("post_reset_dout", dout, 32'h0000_00C3);
    ack_rx();

    // drain scoreboard with a bounded wait
    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 200) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("queue_drain", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
